// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift unit: op encodings, FSM states,
// and op legality check.
package shift_pkg;

    localparam logic [2:0] SH_SLL = 3'd0;
    localparam logic [2:0] SH_SRL = 3'd1;
    localparam logic [2:0] SH_SRA = 3'd2;
    localparam logic [2:0] SH_ROL = 3'd3;
    localparam logic [2:0] SH_ROR = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= SH_ROR;
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between the execute stage and the shift unit.
// The master drives operands and out_ready; the slave returns result and status.
interface shift_unit_if #(
    parameter int XLEN = 32
);
    localparam int SHW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [SHW-1:0]  shamt;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic            busy;

    modport master (
        output in_valid, op, operand_a, shamt, out_ready,
        input  in_ready, out_valid, result, illegal, busy
    );

    modport slave (
        input  in_valid, op, operand_a, shamt, out_ready,
        output in_ready, out_valid, result, illegal, busy
    );

endinterface

// File: rtl/shift_step.sv
// One shift/rotate step of at most STEP bits; purely combinational.
// SRA fills from the sign latched at accept time, not from the current acc MSB.
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    localparam int DW  = $clog2(STEP) + 1
) (
    input  logic [XLEN-1:0] acc,
    input  logic [2:0]      op,
    input  logic [DW-1:0]   d,
    input  logic            sign,
    output logic [XLEN-1:0] nxt
);

    logic [2*XLEN-1:0] sra_ext;
    int                back;

    always_comb begin
        sra_ext = {{XLEN{sign}}, acc} >> d;
        // A zero-distance rotate shifts the wrap-around half by XLEN, which yields 0.
        back    = XLEN - int'(d);
        nxt     = acc;
        case (op)
            SH_SLL:  nxt = acc << d;
            SH_SRL:  nxt = acc >> d;
            SH_SRA:  nxt = sra_ext[XLEN-1:0];
            SH_ROL:  nxt = (acc << d) | (acc >> back);
            SH_ROR:  nxt = (acc >> d) | (acc << back);
            default: nxt = acc;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit: accept in IDLE, shift up to STEP bits per cycle, hold result in DONE.
// Latency 1 + ceil(shamt/STEP) cycles from accept; DONE stalls with stable outputs until out_ready.
module shift_unit
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic         clk,
    input  logic         rst,
    shift_unit_if.slave  bus
);

    localparam int DW = $clog2(STEP) + 1;

    state_t          state;
    logic [XLEN-1:0] acc;
    logic [SHW-1:0]  rem;
    logic [2:0]      op_q;
    logic            sign_q;
    logic            ill_q;
    logic [DW-1:0]   d;
    logic [XLEN-1:0] acc_nxt;
    logic            in_legal;

    assign in_legal = is_legal_op(bus.op);

    always_comb begin
        d = DW'(STEP);
        if (int'(rem) < STEP) begin
            d = DW'(rem);
        end
    end

    shift_step #(
        .XLEN (XLEN),
        .STEP (STEP)
    ) u_step (
        .acc  (acc),
        .op   (op_q),
        .d    (d),
        .sign (sign_q),
        .nxt  (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            rem    <= '0;
            op_q   <= SH_SLL;
            sign_q <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc    <= bus.operand_a;
                        rem    <= bus.shamt;
                        op_q   <= bus.op;
                        sign_q <= bus.operand_a[XLEN-1];
                        ill_q  <= !in_legal;
                        state  <= (bus.shamt == '0 || !in_legal) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    rem <= rem - SHW'(d);
                    if (rem == SHW'(d)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is the only output allowed to see rst combinationally.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.result    = acc;
    assign bus.illegal   = ill_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: two instances (32-bit/STEP 4 and 8-bit/STEP 1) driven from a vector
// table plus random vectors, with hand sequences for backpressure and mid-operation reset.
module tb_shift_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_unit_if #(.XLEN(32)) bus_a ();
    shift_unit_if #(.XLEN(8))  bus_b ();

    shift_unit #(.XLEN(32), .STEP(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    shift_unit #(.XLEN(8),  .STEP(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int          dut;
        logic [2:0]  op;
        logic [31:0] a;
        int          sh;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   sel      = 0;

    logic        ov, ir, bsy, ill;
    logic [31:0] res;

    always_comb begin
        if (sel == 1) begin
            ov = bus_b.out_valid; ir = bus_b.in_ready; bsy = bus_b.busy;
            ill = bus_b.illegal;  res = 32'(bus_b.result);
        end else begin
            ov = bus_a.out_valid; ir = bus_a.in_ready; bsy = bus_a.busy;
            ill = bus_a.illegal;  res = bus_a.result;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [2:0] op, input logic [31:0] a,
                                              input int sh, input int xl);
        logic [31:0] r = '0;
        for (int i = 0; i < xl; i++) begin
            case (op)
                3'd0:    r[i] = (i >= sh) ? a[i-sh] : 1'b0;
                3'd1:    r[i] = (i + sh < xl) ? a[i+sh] : 1'b0;
                3'd2:    r[i] = (i + sh < xl) ? a[i+sh] : a[xl-1];
                3'd3:    r[i] = a[(i - sh + xl) % xl];
                3'd4:    r[i] = a[(i + sh) % xl];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input int sh, input int st);
        if (op > 3'd4 || sh == 0) return 1;
        return 1 + (sh + st - 1) / st;
    endfunction

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                         input int sh, input logic ordy);
        if (sel == 1) begin
            bus_b.in_valid = v; bus_b.op = o; bus_b.operand_a = a[7:0];
            bus_b.shamt = 3'(sh); bus_b.out_ready = ordy;
        end else begin
            bus_a.in_valid = v; bus_a.op = o; bus_a.operand_a = a;
            bus_a.shamt = 5'(sh); bus_a.out_ready = ordy;
        end
    endtask

    task automatic wait_accept(input string nm);
        int k = 0;
        while (!ir && k < 30) begin
            @(posedge clk); #1; k++;
        end
        check({nm, "_in_ready"}, 32'(ir), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!ov && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        string nm;
        nm  = $sformatf("v%0d", idx);
        sel = v.dut;
        drive(1'b1, v.op, v.a, v.sh, 1'b1);
        wait_accept(nm);
        sb.push_back('{res: v.res, ill: v.ill, lat: v.lat});
        // Scramble inputs after acceptance; the latched copy must be used.
        drive(1'b0, ~v.op, ~v.a, ~v.sh, 1'b1);
        wait_valid(lat);
        e = sb.pop_front();
        check({nm, "_out_valid"}, 32'(ov), 32'd1);
        check({nm, "_result"}, res, e.res);
        check({nm, "_illegal"}, 32'(ill), 32'(e.ill));
        check({nm, "_latency"}, 32'(lat), 32'(e.lat));
        @(posedge clk); #1;
        check({nm, "_idle_after"}, 32'(bsy), 32'd0);
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t v;

        tbl.push_back('{dut: 0, op: 3'd0, a: 32'h1,        sh: 3,  res: 32'h8,        ill: 1'b0, lat: 2});
        tbl.push_back('{dut: 0, op: 3'd2, a: 32'h80000000, sh: 31, res: 32'hFFFFFFFF, ill: 1'b0, lat: 9});
        tbl.push_back('{dut: 0, op: 3'd1, a: 32'h80000000, sh: 31, res: 32'h00000001, ill: 1'b0, lat: 9});
        tbl.push_back('{dut: 0, op: 3'd4, a: 32'h12345678, sh: 8,  res: 32'h78123456, ill: 1'b0, lat: 3});
        tbl.push_back('{dut: 0, op: 3'd3, a: 32'h12345678, sh: 0,  res: 32'h12345678, ill: 1'b0, lat: 1});
        tbl.push_back('{dut: 0, op: 3'd6, a: 32'hDEADBEEF, sh: 5,  res: 32'hDEADBEEF, ill: 1'b1, lat: 1});
        tbl.push_back('{dut: 0, op: 3'd3, a: 32'h80000001, sh: 4,  res: 32'h00000018, ill: 1'b0, lat: 2});
        tbl.push_back('{dut: 0, op: 3'd2, a: 32'h40000000, sh: 30, res: 32'h00000001, ill: 1'b0, lat: 9});
        tbl.push_back('{dut: 1, op: 3'd0, a: 32'h81,       sh: 7,  res: 32'h80,       ill: 1'b0, lat: 8});
        tbl.push_back('{dut: 1, op: 3'd2, a: 32'h80,       sh: 7,  res: 32'hFF,       ill: 1'b0, lat: 8});
        tbl.push_back('{dut: 1, op: 3'd3, a: 32'h81,       sh: 1,  res: 32'h03,       ill: 1'b0, lat: 2});
        tbl.push_back('{dut: 1, op: 3'd4, a: 32'h81,       sh: 3,  res: 32'h30,       ill: 1'b0, lat: 4});
        tbl.push_back('{dut: 1, op: 3'd5, a: 32'hA5,       sh: 6,  res: 32'hA5,       ill: 1'b1, lat: 1});
        for (int i = 0; i < 24; i++) begin
            int xl;
            int st;
            v.dut = i % 2;
            xl    = (v.dut == 1) ? 8 : 32;
            st    = (v.dut == 1) ? 1 : 4;
            v.op  = 3'($urandom_range(0, 7));
            v.a   = $urandom;
            if (v.dut == 1) v.a = v.a & 32'hFF;
            v.sh  = $urandom_range(0, xl - 1);
            v.res = ref_shift(v.op, v.a, v.sh, xl);
            v.ill = (v.op > 3'd4);
            v.lat = ref_lat(v.op, v.sh, st);
            tbl.push_back(v);
        end

        sel = 1; drive(1'b0, 3'd0, 32'h0, 0, 1'b0);
        sel = 0; drive(1'b0, 3'd0, 32'h0, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check($sformatf("rst%0d_in_ready", s), 32'(ir), 32'd0);
            check($sformatf("rst%0d_out_valid", s), 32'(ov), 32'd0);
            check($sformatf("rst%0d_busy", s), 32'(bsy), 32'd0);
            check($sformatf("rst%0d_illegal", s), 32'(ill), 32'd0);
            check($sformatf("rst%0d_result", s), res, 32'd0);
        end
        sel = 0;
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(ir), 32'd1);
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // Backpressure: result held, second request not taken until after the handshake.
        sel = 0;
        drive(1'b1, 3'd1, 32'hF0F0F0F0, 4, 1'b0);
        wait_accept("bp");
        sb.push_back('{res: 32'h0F0F0F0F, ill: 1'b0, lat: 2});
        drive(1'b0, 3'd0, 32'h0, 0, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'(sb[0].lat));
        drive(1'b1, 3'd0, 32'h1, 1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_result", c), res, sb[0].res);
            check($sformatf("bp_hold%0d_out_valid", c), 32'(ov), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", c), 32'(ir), 32'd0);
        end
        void'(sb.pop_front());
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_handshake_busy", 32'(bsy), 32'd0);
        check("bp_handshake_in_ready", 32'(ir), 32'd1);
        @(posedge clk); #1;
        check("bp_second_accept_busy", 32'(bsy), 32'd1);
        sb.push_back('{res: 32'h2, ill: 1'b0, lat: 2});
        drive(1'b0, 3'd0, 32'h0, 0, 1'b1);
        wait_valid(lat);
        check("bp_second_latency", 32'(lat), 32'(sb[0].lat));
        check("bp_second_result", res, sb.pop_front().res);
        @(posedge clk); #1;

        // Reset in the middle of a long SLL aborts it without a response.
        drive(1'b1, 3'd0, 32'h1, 20, 1'b1);
        wait_accept("ra");
        drive(1'b0, 3'd0, 32'h0, 0, 1'b1);
        @(posedge clk); #1;
        check("ra_busy_mid_shift", 32'(bsy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("ra_busy_in_reset", 32'(bsy), 32'd0);
        check("ra_in_ready_in_reset", 32'(ir), 32'd0);
        check("ra_out_valid_in_reset", 32'(ov), 32'd0);
        rst = 1'b0;
        #1;
        check("ra_in_ready_after", 32'(ir), 32'd1);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ov) seen++;
        end
        check("ra_no_out_valid", 32'(seen), 32'd0);
        check("ra_scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
